// File: rtl/input_debouncer_pkg.sv
// Shared front-end constants: default debounce length and the counter width
// derivation reused by the button and counter conditioning blocks.
package input_debouncer_pkg;

    // Simulation default; board builds override with a realistic settle time.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // Width able to hold 0..cycles without wrapping; never less than one bit.
    function automatic int cnt_width(input int cycles);
        if (cycles < 1) begin
            return 1;
        end
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: two-flop synchronizer, mismatch counter, stable level
// register and registered one-cycle rise/fall pulses.
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             rise_q;
    logic             fall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            // Any agreeing cycle discards progress, so bounces never accumulate.
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= s2;
                cnt    <= '0;
                rise_q <= s2;
                fall_q <= ~s2;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    assign level = stable;
    assign rise  = rise_q;
    assign fall  = fall_q;

    rise_fall_exclusive: assert property (@(posedge clock) !(rise_q && fall_q));

endmodule

// File: rtl/input_debouncer.sv
// Two independent debounce lanes conditioning raw board switches into clean
// levels and edge pulses for the bitwise-operator block.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic io_rawInput1,
    input  logic io_rawInput2,
    output logic io_input1,
    output logic io_input2,
    output logic io_rise1,
    output logic io_fall1,
    output logic io_rise2,
    output logic io_fall2
);

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_channel1 (
        .clock (clock),
        .reset (reset),
        .raw   (io_rawInput1),
        .level (io_input1),
        .rise  (io_rise1),
        .fall  (io_fall1)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_channel2 (
        .clock (clock),
        .reset (reset),
        .raw   (io_rawInput2),
        .level (io_input2),
        .rise  (io_rise2),
        .fall  (io_fall2)
    );

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: default-length instance plus a
// single-cycle instance for the minimum-length corner.
module tb_input_debouncer;

    logic clock;
    logic reset;
    logic raw1;
    logic raw2;

    logic in1, in2, rise1, fall1, rise2, fall2;
    logic f_in1, f_in2, f_rise1, f_fall1, f_rise2, f_fall2;

    logic [7:0] exp_q[$];
    logic [1:0] fast_q[$];

    int n_compared;
    int n_mismatched;

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    input_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_rawInput1 (raw1),
        .io_rawInput2 (raw2),
        .io_input1    (in1),
        .io_input2    (in2),
        .io_rise1     (rise1),
        .io_fall1     (fall1),
        .io_rise2     (rise2),
        .io_fall2     (fall2)
    );

    input_debouncer #(.DEBOUNCE_CYCLES(1)) dut_fast (
        .clock        (clock),
        .reset        (reset),
        .io_rawInput1 (raw1),
        .io_rawInput2 (raw2),
        .io_input1    (f_in1),
        .io_input2    (f_in2),
        .io_rise1     (f_rise1),
        .io_fall1     (f_fall1),
        .io_rise2     (f_rise2),
        .io_fall2     (f_fall2)
    );

    task automatic check_eq(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %b expected %b", tag, actual, expected);
        end
    endtask

    // Expected word layout: {2'b0, in2, rise2, fall2, in1, rise1, fall1}
    task automatic expect_n(input logic [5:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({2'b00, v});
    endtask

    task automatic run_cycles(input string tag, input int n);
        logic [7:0] exp_v;
        logic [1:0] fast_v;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
            check_eq($sformatf("%s[%0d]", tag, i),
                     {2'b00, in2, rise2, fall2, in1, rise1, fall1}, exp_v);
            if (fast_q.size() > 0) begin
                fast_v = fast_q.pop_front();
                check_eq($sformatf("%s_fast[%0d]", tag, i),
                         {6'b0, f_in1, f_rise1}, {6'b0, fast_v});
            end
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset = 1'b1;
        raw1  = 1'b1;
        raw2  = 1'b1;

        // Reset with both raws high, then both rise 6 edges after release.
        expect_n(6'b000_000, 2);
        run_cycles("reset_hold", 2);
        reset = 1'b0;
        expect_n(6'b000_000, 5);
        expect_n(6'b110_110, 1);
        expect_n(6'b100_100, 3);
        run_cycles("reset_rise", 9);

        // Simultaneous fall on both channels.
        raw1 = 1'b0;
        raw2 = 1'b0;
        expect_n(6'b100_100, 5);
        expect_n(6'b001_001, 1);
        expect_n(6'b000_000, 3);
        run_cycles("dual_fall", 9);

        // Clean rising edge on channel 1; fast instance follows after edge 2.
        raw1 = 1'b1;
        expect_n(6'b000_000, 5);
        expect_n(6'b000_110, 1);
        expect_n(6'b000_100, 3);
        fast_q.push_back(2'b00);
        fast_q.push_back(2'b00);
        fast_q.push_back(2'b11);
        for (int i = 0; i < 6; i++) fast_q.push_back(2'b10);
        run_cycles("clean_rise", 9);

        // Return channel 1 to 0 before the bounce test.
        raw1 = 1'b0;
        expect_n(6'b000_100, 5);
        expect_n(6'b000_001, 1);
        expect_n(6'b000_000, 2);
        run_cycles("ch1_fall", 8);

        // Bounce: toggling every cycle never reaches the output.
        for (int i = 0; i < 12; i++) begin
            raw1 = (i % 2 == 0);
            expect_n(6'b000_000, 1);
            run_cycles("bounce", 1);
        end
        raw1 = 1'b0;
        expect_n(6'b000_000, 6);
        run_cycles("bounce_settle", 6);

        // Near threshold: 3 mismatch cycles rejected.
        raw2 = 1'b1;
        expect_n(6'b000_000, 3);
        run_cycles("near3_pulse", 3);
        raw2 = 1'b0;
        expect_n(6'b000_000, 8);
        run_cycles("near3_after", 8);

        // Held long enough: exactly one rise on channel 2.
        raw2 = 1'b1;
        expect_n(6'b000_000, 5);
        expect_n(6'b110_000, 1);
        expect_n(6'b100_000, 3);
        run_cycles("ch2_rise", 9);

        // Reset two edges into a channel-1 count discards progress.
        raw1 = 1'b1;
        expect_n(6'b100_000, 2);
        run_cycles("midcount_pre", 2);
        reset = 1'b1;
        expect_n(6'b000_000, 1);
        run_cycles("midcount_reset", 1);
        reset = 1'b0;
        expect_n(6'b000_000, 5);
        expect_n(6'b110_110, 1);
        expect_n(6'b100_100, 3);
        run_cycles("midcount_rise", 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
